// File: rtl/rv32i_types.sv
// Shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_port_t  : which port (A = fetch, B = data) holds or last held the grant
//   pick_port   : fairness rule used when the arbiter samples requests in IDLE
package rv32i_types;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_A = 3'd1,
        ST_BUSY_B = 3'd2,
        ST_RESP_A = 3'd3,
        ST_RESP_B = 3'd4
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arb_port_t;

    // A single requester always wins; on a tie the port not granted last wins.
    function automatic arb_port_t pick_port(input logic req_a, input logic req_b,
                                            input arb_port_t last_grant);
        arb_port_t win_s;
        if (req_a && req_b) begin
            win_s = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            win_s = PORT_B;
        end else begin
            win_s = PORT_A;
        end
        return win_s;
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Request/response capture shared by both arbiter ports.
// On grant it freezes the winning port's op, address, write data and mask so the
// backing memory sees stable fields even if the core changes its inputs. Port A
// is read-only, so its write data and mask are captured as zero. Read data is
// captured per port when the backing memory completes a read.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   grant, grant_port        capture strobe and the winning port
//   address_a                port A address
//   write, address_b, wdata, wmask   port B request fields
//   load_rdata_a/_b, mem_rdata       read data capture strobes and data
//   op_write, lat_*          latched request fields driven to the backing port
//   rdata_a, rdata_b         per-port held read data
module arb_req_latch
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                grant,
    input  arb_port_t           grant_port,
    input  logic [ADDR_W-1:0]   address_a,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic                load_rdata_a,
    input  logic                load_rdata_b,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                op_write,
    output logic [ADDR_W-1:0]   lat_address,
    output logic [DATA_W-1:0]   lat_wdata,
    output logic [DATA_W/8-1:0] lat_wmask,
    output logic [DATA_W-1:0]   rdata_a,
    output logic [DATA_W-1:0]   rdata_b
);

    logic                op_write_r;
    logic [ADDR_W-1:0]   address_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W/8-1:0] wmask_r;
    logic [DATA_W-1:0]   rdata_a_r;
    logic [DATA_W-1:0]   rdata_b_r;

    // Capture request fields on grant and read data on backing completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write_r <= 1'b0;
            address_r  <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wmask_r    <= {(DATA_W/8){1'b0}};
            rdata_a_r  <= {DATA_W{1'b0}};
            rdata_b_r  <= {DATA_W{1'b0}};
        end else begin
            if (grant) begin
                if (grant_port == PORT_B) begin
                    // write wins when read_b and write are both high
                    op_write_r <= write;
                    address_r  <= address_b;
                    wdata_r    <= wdata;
                    wmask_r    <= wmask;
                end else begin
                    op_write_r <= 1'b0;
                    address_r  <= address_a;
                    wdata_r    <= {DATA_W{1'b0}};
                    wmask_r    <= {(DATA_W/8){1'b0}};
                end
            end
            if (load_rdata_a) begin
                rdata_a_r <= mem_rdata;
            end
            if (load_rdata_b) begin
                rdata_b_r <= mem_rdata;
            end
        end
    end

    assign op_write    = op_write_r;
    assign lat_address = address_r;
    assign lat_wdata   = wdata_r;
    assign lat_wmask   = wmask_r;
    assign rdata_a     = rdata_a_r;
    assign rdata_b     = rdata_b_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory responder: serializes the read-only fetch port (A) and the
// read/write data port (B) onto one backing-memory port, returning a one-cycle
// resp pulse to the served port. Every output comes from a register.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   read_a, address_a, resp_a, rdata_a port A (fetch)
//   read_b, write, address_b, wdata, wmask, resp_b, rdata_b   port B (data)
//   mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
//   mem_rdata, mem_resp                backing memory port
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_a,
    input  logic [ADDR_W-1:0]   address_a,
    output logic                resp_a,
    output logic [DATA_W-1:0]   rdata_a,
    input  logic                read_b,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    output logic                resp_b,
    output logic [DATA_W-1:0]   rdata_b,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);

    arb_state_t state_r;
    arb_port_t  last_grant_r;
    logic       mem_read_r;
    logic       mem_write_r;
    logic       resp_a_r;
    logic       resp_b_r;

    logic       req_b_s;
    logic       grant_s;
    arb_port_t  grant_port_s;
    logic       op_write_s;
    logic       load_rdata_a_s;
    logic       load_rdata_b_s;

    // Grant decision (IDLE only) and read data capture enables.
    always_comb begin
        req_b_s        = read_b | write;
        grant_port_s   = pick_port(read_a, req_b_s, last_grant_r);
        if (state_r == ST_IDLE) begin
            grant_s = read_a | req_b_s;
        end else begin
            grant_s = 1'b0;
        end
        load_rdata_a_s = (state_r == ST_BUSY_A) && mem_resp;
        load_rdata_b_s = (state_r == ST_BUSY_B) && mem_resp && !op_write_s;
    end

    // Arbiter FSM with registered strobes and response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= PORT_A;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            resp_a_r     <= 1'b0;
            resp_b_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        last_grant_r <= grant_port_s;
                        if (grant_port_s == PORT_B) begin
                            state_r     <= ST_BUSY_B;
                            mem_read_r  <= ~write;
                            mem_write_r <= write;
                        end else begin
                            state_r     <= ST_BUSY_A;
                            mem_read_r  <= 1'b1;
                            mem_write_r <= 1'b0;
                        end
                    end
                end
                ST_BUSY_A: begin
                    if (mem_resp) begin
                        state_r    <= ST_RESP_A;
                        mem_read_r <= 1'b0;
                        resp_a_r   <= 1'b1;
                    end
                end
                ST_BUSY_B: begin
                    if (mem_resp) begin
                        state_r     <= ST_RESP_B;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        resp_b_r    <= 1'b1;
                    end
                end
                // The response cycle always returns to IDLE so the core can
                // present its next address before requests are sampled again.
                ST_RESP_A: begin
                    state_r  <= ST_IDLE;
                    resp_a_r <= 1'b0;
                end
                ST_RESP_B: begin
                    state_r  <= ST_IDLE;
                    resp_b_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    resp_a_r    <= 1'b0;
                    resp_b_r    <= 1'b0;
                end
            endcase
        end
    end

    arb_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_latch (
        .clk          (clk),
        .rst          (rst),
        .grant        (grant_s),
        .grant_port   (grant_port_s),
        .address_a    (address_a),
        .write        (write),
        .address_b    (address_b),
        .wdata        (wdata),
        .wmask        (wmask),
        .load_rdata_a (load_rdata_a_s),
        .load_rdata_b (load_rdata_b_s),
        .mem_rdata    (mem_rdata),
        .op_write     (op_write_s),
        .lat_address  (mem_address),
        .lat_wdata    (mem_wdata),
        .lat_wmask    (mem_wmask),
        .rdata_a      (rdata_a),
        .rdata_b      (rdata_b)
    );

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign resp_a    = resp_a_r;
    assign resp_b    = resp_b_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model (pending requests per port,
// tie-break by last grant, expected held read data per port).
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          read_a = 1'b0;
    logic [AW-1:0] address_a = 32'h0;
    logic          resp_a;
    logic [DW-1:0] rdata_a;
    logic          read_b = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] address_b = 32'h0;
    logic [DW-1:0] wdata = 32'h0;
    logic [MW-1:0] wmask = 4'h0;
    logic          resp_b;
    logic [DW-1:0] rdata_b;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_rdata = 32'h0;
    logic          mem_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    // model state: expected held read data and last granted port (1 = B)
    logic [DW-1:0] exp_rdata_a;
    logic [DW-1:0] exp_rdata_b;
    bit            last_b;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write(write), .address_b(address_b), .wdata(wdata),
        .wmask(wmask), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; read_a = 1'b0; read_b = 1'b0; write = 1'b0; mem_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_rdata_a = 32'h0; exp_rdata_b = 32'h0; last_b = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({resp_a, resp_b} !== 2'b00) begin bad++; $display("FAIL reset_resp got=%b want=00", {resp_a, resp_b}); end
        total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {mem_read, mem_write}); end
        total++; if ({rdata_a, rdata_b} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {rdata_a, rdata_b}); end
        total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL reset_mem_address got=%h want=0", mem_address); end
        total++; if ({mem_wdata, mem_wmask} !== 36'h0) begin bad++; $display("FAIL reset_mem_wdata_wmask got=%h want=0", {mem_wdata, mem_wmask}); end
    endtask

    task automatic test_fetch();
        read_a = 1'b1; address_a = 32'h60;
        tick();
        total++; if ({mem_read, mem_write} !== 2'b10) begin bad++; $display("FAIL fetch_strobes got=%b want=10", {mem_read, mem_write}); end
        total++; if (mem_address !== 32'h60) begin bad++; $display("FAIL fetch_address got=%h want=60", mem_address); end
        total++; if (mem_wmask !== 4'h0) begin bad++; $display("FAIL fetch_wmask got=%h want=0", mem_wmask); end
        tick(); tick();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        mem_resp = 1'b0; read_a = 1'b0; exp_rdata_a = 32'h0000_0013;
        total++; if ({resp_a, resp_b} !== 2'b10) begin bad++; $display("FAIL fetch_resp got=%b want=10", {resp_a, resp_b}); end
        total++; if (rdata_a !== exp_rdata_a) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", rdata_a, exp_rdata_a); end
        tick(); tick();
        total++; if ({resp_a, mem_read} !== 2'b00) begin bad++; $display("FAIL fetch_after got=%b want=00", {resp_a, mem_read}); end
    endtask

    task automatic test_write();
        write = 1'b1; address_b = 32'h100; wdata = 32'hDEAD_BEEF; wmask = 4'b0011;
        tick();
        total++; if ({mem_read, mem_write} !== 2'b01) begin bad++; $display("FAIL write_strobes got=%b want=01", {mem_read, mem_write}); end
        total++; if ({mem_address, mem_wdata, mem_wmask} !== {32'h100, 32'hDEAD_BEEF, 4'b0011})
            begin bad++; $display("FAIL write_fields got=%h/%h/%h want=100/deadbeef/3", mem_address, mem_wdata, mem_wmask); end
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_resp = 1'b0; write = 1'b0;
        total++; if ({resp_a, resp_b} !== 2'b01) begin bad++; $display("FAIL write_resp got=%b want=01", {resp_a, resp_b}); end
        total++; if (rdata_b !== exp_rdata_b) begin bad++; $display("FAIL write_rdata_b got=%h want=%h", rdata_b, exp_rdata_b); end
        tick();
    endtask

    task automatic test_drop();
        read_a = 1'b1; address_a = 32'h80;
        tick();
        read_a = 1'b0; address_a = 32'hAAA;
        tick();
        total++; if ({mem_read, mem_address} !== {1'b1, 32'h80}) begin bad++; $display("FAIL drop_latched got=%b/%h want=1/80", mem_read, mem_address); end
        mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_resp = 1'b0; exp_rdata_a = 32'h1234_5678;
        total++; if (resp_a !== 1'b1) begin bad++; $display("FAIL drop_resp got=%b want=1", resp_a); end
        tick(); tick(); tick();
        total++; if ({mem_read, resp_a} !== 2'b00) begin bad++; $display("FAIL drop_no_second got=%b want=00", {mem_read, resp_a}); end
    endtask

    task automatic test_tie();
        do_reset();
        read_a = 1'b1; address_a = 32'h200; read_b = 1'b1; address_b = 32'h300;
        tick();
        total++; if ({mem_read, mem_address} !== {1'b1, 32'h300}) begin bad++; $display("FAIL tie1_b_first got=%b/%h want=1/300", mem_read, mem_address); end
        mem_resp = 1'b1; mem_rdata = 32'h1111_0000;
        tick();
        mem_resp = 1'b0; exp_rdata_b = 32'h1111_0000;
        total++; if ({resp_a, resp_b, rdata_b} !== {2'b01, exp_rdata_b}) begin bad++; $display("FAIL tie1_resp got=%b%b/%h want=01/%h", resp_a, resp_b, rdata_b, exp_rdata_b); end
        address_b = 32'h304;
        tick(); tick();
        total++; if (mem_address !== 32'h200) begin bad++; $display("FAIL tie2_a_wins got=%h want=200", mem_address); end
        mem_resp = 1'b1; mem_rdata = 32'h2222_0000;
        tick();
        mem_resp = 1'b0; read_a = 1'b0; exp_rdata_a = 32'h2222_0000;
        total++; if ({resp_a, rdata_a} !== {1'b1, exp_rdata_a}) begin bad++; $display("FAIL tie2_resp got=%b/%h want=1/%h", resp_a, rdata_a, exp_rdata_a); end
        tick(); tick();
        total++; if ({mem_read, mem_address} !== {1'b1, 32'h304}) begin bad++; $display("FAIL tie3_b_next got=%b/%h want=1/304", mem_read, mem_address); end
        mem_resp = 1'b1; mem_rdata = 32'h3333_0000;
        tick();
        mem_resp = 1'b0; read_b = 1'b0; exp_rdata_b = 32'h3333_0000;
        tick();
    endtask

    task automatic test_reset_busy();
        read_b = 1'b1; address_b = 32'h40;
        tick();
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rstbusy_strobe got=%b want=1", mem_read); end
        rst = 1'b1; read_b = 1'b0;
        tick();
        rst = 1'b0; exp_rdata_a = 32'h0; exp_rdata_b = 32'h0; last_b = 1'b0;
        total++; if ({resp_a, resp_b, mem_read, mem_write, mem_address, rdata_a, rdata_b} !== 100'h0)
            begin bad++; $display("FAIL rstbusy_zero got=%b%b%b%b/%h/%h/%h want=0", resp_a, resp_b, mem_read, mem_write, mem_address, rdata_a, rdata_b); end
        mem_resp = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_resp = 1'b0;
        total++; if ({resp_b, mem_read, rdata_b} !== {2'b00, exp_rdata_b}) begin bad++; $display("FAIL rstbusy_ignored got=%b%b/%h want=00/0", resp_b, mem_read, rdata_b); end
        tick();
        total++; if ({resp_a, resp_b, mem_read, mem_write} !== 4'b0000) begin bad++; $display("FAIL rstbusy_idle got=%b want=0000", {resp_a, resp_b, mem_read, mem_write}); end
    endtask

    task automatic test_back_to_back();
        int  last_grant_cycle = -1;
        int  grants = 0;
        bit  prev_rd = 1'b0;
        bit  prev_resp = 1'b0;
        do_reset();
        read_a = 1'b1; address_a = 32'h400;
        for (int c = 0; c < 40; c++) begin
            tick();
            mem_resp = mem_read; mem_rdata = $urandom;
            if (mem_read && !prev_rd) begin
                grants++;
                if (last_grant_cycle >= 0) begin
                    total++; if (c - last_grant_cycle != 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=3", c - last_grant_cycle); end
                end
                last_grant_cycle = c;
            end
            if (prev_resp) begin
                total++; if (resp_a !== 1'b0) begin bad++; $display("FAIL b2b_resp_double got=%b want=0", resp_a); end
            end
            prev_rd = mem_read; prev_resp = resp_a;
        end
        total++; if (grants < 12) begin bad++; $display("FAIL b2b_grant_count got=%0d want>=12", grants); end
        read_a = 1'b0;
        mem_resp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            mem_resp = mem_read;
        end
        mem_resp = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit            pa, pb, pw, wb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] wd, rd;
        logic [MW-1:0] wm;
        int            k;
        do_reset();
        pa = 1'b0; pb = 1'b0; pw = 1'b0; aa = 32'h0; ab = 32'h0; wd = 32'h0; wm = 4'h0;
        for (int n = 0; n < 40; n++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin pa = 1'b1; aa = $urandom; end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; pw = 1'($urandom_range(0, 1)); ab = $urandom; wd = $urandom; wm = 4'($urandom_range(0, 15));
            end
            if (!pa && !pb) begin pa = 1'b1; aa = $urandom; end
            read_a = pa; address_a = aa;
            read_b = pb && (!pw || ($urandom_range(0, 1) == 1));
            write = pb && pw; address_b = ab; wdata = wd; wmask = wm;
            wb = (pa && pb) ? !last_b : pb;
            last_b = wb;
            k = $urandom_range(1, 4);
            tick();
            total++; if ({mem_read, mem_write} !== (wb ? {!pw, pw} : 2'b10)) begin bad++; $display("FAIL rnd_strobes n=%0d got=%b%b wb=%0d pw=%0d", n, mem_read, mem_write, wb, pw); end
            total++; if (mem_address !== (wb ? ab : aa)) begin bad++; $display("FAIL rnd_address n=%0d got=%h want=%h", n, mem_address, wb ? ab : aa); end
            total++; if (mem_wmask !== (wb ? wm : 4'h0)) begin bad++; $display("FAIL rnd_wmask n=%0d got=%h want=%h", n, mem_wmask, wb ? wm : 4'h0); end
            if (wb && pw) begin
                total++; if (mem_wdata !== wd) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h want=%h", n, mem_wdata, wd); end
            end
            for (int j = 1; j < k; j++) begin
                tick();
                total++; if ((mem_read | mem_write) !== 1'b1) begin bad++; $display("FAIL rnd_strobe_held n=%0d got=%b want=1", n, mem_read | mem_write); end
            end
            rd = $urandom;
            mem_resp = 1'b1; mem_rdata = rd;
            tick();
            mem_resp = 1'b0;
            if (wb) begin
                if (!pw) exp_rdata_b = rd;
                pb = 1'b0; read_b = 1'b0; write = 1'b0;
            end else begin
                exp_rdata_a = rd;
                pa = 1'b0; read_a = 1'b0;
            end
            total++; if ({resp_a, resp_b} !== {!wb, wb}) begin bad++; $display("FAIL rnd_resp n=%0d got=%b%b want=%b%b", n, resp_a, resp_b, !wb, wb); end
            total++; if (rdata_a !== exp_rdata_a) begin bad++; $display("FAIL rnd_rdata_a n=%0d got=%h want=%h", n, rdata_a, exp_rdata_a); end
            total++; if (rdata_b !== exp_rdata_b) begin bad++; $display("FAIL rnd_rdata_b n=%0d got=%h want=%h", n, rdata_b, exp_rdata_b); end
            tick();
            total++; if ({resp_a, resp_b, mem_read, mem_write} !== 4'b0000) begin bad++; $display("FAIL rnd_idle n=%0d got=%b want=0000", n, {resp_a, resp_b, mem_read, mem_write}); end
        end
        read_a = 1'b0; read_b = 1'b0; write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_drop();
        test_tie();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
